uart_lockstep_checker: RTL and testbench

//   Downstream consumer of the self-composed DarkRISCV product harness.

---
 rtl/uart_lockstep_checker.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_lockstep_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lockstep_checker.sv
// uart_lockstep_checker: deserialises the TXD lines of two lockstep copies,
// buffers bytes per side and compares them pairwise in arrival order.
// Divergence is sticky and the first offending pair is captured.
// Optional macro RX_SYNC_EN: adds a 2-flop synchroniser (reset value 1) on each
// TXD input, moving every sampling point and the result latency by +2 cycles.
// Ports:
//   XCLK, XRES             clock (rising edge), synchronous active-low reset
//   UART_TXDLeft/Right     8N1 serial lines, idle high, LSB first
//   MISMATCH, MISBYTE_L/R  sticky divergence flag and captured bytes
//   MATCH_CNT              equal pairs compared, saturating
//   OVERFLOW, FRAME_ERR    sticky per side, bit0 = left, bit1 = right
//   QUIESCENT              both receivers idle and both FIFOs empty

// uart_lockstep_side: one UART receiver plus its byte FIFO.
// Ports: rxd serial in, pop from compare stage, head/not_empty FIFO view,
//        rx_idle receiver state, overflow/frame_err sticky error flags.
module uart_lockstep_side #(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       pop,
  output logic [7:0] head,
  output logic       not_empty,
  output logic       rx_idle,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [AW:0] DEPTH_C     = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_C       = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic line;

`ifdef RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rxd};
  end
  assign line = sync[1];
`else
  assign line = rxd;
`endif

  state_t      state, state_nxt;
  logic        armed;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tick;

  logic start_go, start_ok, sample, push, ferr_set;

  assign tick = (cnt == 16'd0);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (armed && !line) state_nxt = START;
      START: if (tick) state_nxt = line ? IDLE : DATA;
      DATA:  if (tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output / strobe logic
  always_comb begin
    start_go = 1'b0;
    start_ok = 1'b0;
    sample   = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE:  start_go = armed && !line;
      START: start_ok = tick && !line;
      DATA:  sample   = tick;
      STOP: begin
        push     = tick && line;
        ferr_set = tick && !line;
      end
      default: ;
    endcase
  end

  assign rx_idle = (state == IDLE);

  // receiver datapath; the arm bit blocks a false start when the line is low out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      armed <= armed | line;
      if (start_go)               cnt <= HALF_RELOAD;
      else if (start_ok || sample) cnt <= FULL_RELOAD;
      else if (!tick)             cnt <= cnt - 16'd1;
      if (start_ok) bit_idx <= 3'd0;
      if (sample) begin
        shreg   <= {line, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (ferr_set) frame_err <= 1'b1;
    end
  end

  // byte FIFO; a pop in the same cycle frees the slot for a push to a full FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, accept;

  assign full      = (count == DEPTH_C);
  assign accept    = push && (!full || pop);
  assign not_empty = (count != '0);
  assign head      = mem[rptr];

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule

module uart_lockstep_checker #(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        UART_TXDLeft,
  input  logic        UART_TXDRight,
  output logic        MISMATCH,
  output logic [7:0]  MISBYTE_L,
  output logic [7:0]  MISBYTE_R,
  output logic [15:0] MATCH_CNT,
  output logic [1:0]  OVERFLOW,
  output logic [1:0]  FRAME_ERR,
  output logic        QUIESCENT
);

  logic [7:0] head_l, head_r;
  logic       ne_l, ne_r, idle_l, idle_r;
  logic       ovf_l, ovf_r, ferr_l, ferr_r;
  logic       pop;

  // pop both heads together only when a full pair is available
  assign pop = ne_l && ne_r;

  uart_lockstep_side #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) u_left (
    .clk       (XCLK),
    .rst_n     (XRES),
    .rxd       (UART_TXDLeft),
    .pop       (pop),
    .head      (head_l),
    .not_empty (ne_l),
    .rx_idle   (idle_l),
    .overflow  (ovf_l),
    .frame_err (ferr_l)
  );

  uart_lockstep_side #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) u_right (
    .clk       (XCLK),
    .rst_n     (XRES),
    .rxd       (UART_TXDRight),
    .pop       (pop),
    .head      (head_r),
    .not_empty (ne_r),
    .rx_idle   (idle_r),
    .overflow  (ovf_r),
    .frame_err (ferr_r)
  );

  // compare stage: popped pair is registered, then judged one cycle later
  logic       cmp_vld;
  logic [7:0] cmp_l, cmp_r;

  always_ff @(posedge XCLK) begin
    if (!XRES) begin
      cmp_vld   <= 1'b0;
      cmp_l     <= 8'd0;
      cmp_r     <= 8'd0;
      MISMATCH  <= 1'b0;
      MISBYTE_L <= 8'd0;
      MISBYTE_R <= 8'd0;
      MATCH_CNT <= 16'd0;
    end else begin
      cmp_vld <= pop;
      if (pop) begin
        cmp_l <= head_l;
        cmp_r <= head_r;
      end
      if (cmp_vld) begin
        if (cmp_l == cmp_r) begin
          if (MATCH_CNT != 16'hFFFF) MATCH_CNT <= MATCH_CNT + 16'd1;
        end else if (!MISMATCH) begin
          MISMATCH  <= 1'b1;
          MISBYTE_L <= cmp_l;
          MISBYTE_R <= cmp_r;
        end
      end
    end
  end

  assign OVERFLOW  = {ovf_r, ovf_l};
  assign FRAME_ERR = {ferr_r, ferr_l};
  assign QUIESCENT = idle_l && idle_r && !ne_l && !ne_r;

endmodule

// File: tb/tb_uart_lockstep_checker.sv
// Bench for uart_lockstep_checker (BAUD_DIV=4, FIFO_DEPTH=4): directed scenarios
// plus randomized byte rounds, checked against a frame-level queue model.
module tb_uart_lockstep_checker;

  localparam int DEPTH = 4;
  localparam int BIT_CYC = 4;

  logic        XCLK = 1'b0;
  logic        XRES = 1'b0;
  logic        UART_TXDLeft = 1'b1;
  logic        UART_TXDRight = 1'b1;
  logic        MISMATCH;
  logic [7:0]  MISBYTE_L, MISBYTE_R;
  logic [15:0] MATCH_CNT;
  logic [1:0]  OVERFLOW, FRAME_ERR;
  logic        QUIESCENT;

  uart_lockstep_checker #(.BAUD_DIV(4), .FIFO_DEPTH(DEPTH)) dut (
    .XCLK          (XCLK),
    .XRES          (XRES),
    .UART_TXDLeft  (UART_TXDLeft),
    .UART_TXDRight (UART_TXDRight),
    .MISMATCH      (MISMATCH),
    .MISBYTE_L     (MISBYTE_L),
    .MISBYTE_R     (MISBYTE_R),
    .MATCH_CNT     (MATCH_CNT),
    .OVERFLOW      (OVERFLOW),
    .FRAME_ERR     (FRAME_ERR),
    .QUIESCENT     (QUIESCENT)
  );

  always #5 XCLK = ~XCLK;

  int n_vec = 0;
  int n_miss = 0;

  // per-cycle line levels waiting to be driven, and the level used when empty
  logic wq_l[$];
  logic wq_r[$];
  logic idle_l = 1'b1;
  logic idle_r = 1'b1;

  // reference model: per-side byte queues paired in order
  logic [7:0] mq_l[$];
  logic [7:0] mq_r[$];
  int         m_match;
  logic       m_mis;
  logic [7:0] m_bl, m_br;
  logic [1:0] m_ovf, m_ferr;

  task automatic model_clear();
    mq_l.delete(); mq_r.delete();
    m_match = 0; m_mis = 1'b0; m_bl = 8'd0; m_br = 8'd0;
    m_ovf = 2'b00; m_ferr = 2'b00;
  endtask

  task automatic model_push(input int side, input logic [7:0] b);
    logic [7:0] l, r;
    if (side == 0) begin
      if (mq_l.size() >= DEPTH) m_ovf[0] = 1'b1; else mq_l.push_back(b);
    end else begin
      if (mq_r.size() >= DEPTH) m_ovf[1] = 1'b1; else mq_r.push_back(b);
    end
    while (mq_l.size() > 0 && mq_r.size() > 0) begin
      l = mq_l.pop_front();
      r = mq_r.pop_front();
      if (l == r) begin
        if (m_match < 65535) m_match++;
      end else if (!m_mis) begin
        m_mis = 1'b1; m_bl = l; m_br = r;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic q_exp;
    q_exp = (mq_l.size() == 0) && (mq_r.size() == 0);
    check({tag, ".MISMATCH"},  32'(MISMATCH),  32'(m_mis));
    check({tag, ".MISBYTE_L"}, 32'(MISBYTE_L), 32'(m_bl));
    check({tag, ".MISBYTE_R"}, 32'(MISBYTE_R), 32'(m_br));
    check({tag, ".MATCH_CNT"}, 32'(MATCH_CNT), 32'(m_match));
    check({tag, ".OVERFLOW"},  32'(OVERFLOW),  32'(m_ovf));
    check({tag, ".FRAME_ERR"}, 32'(FRAME_ERR), 32'(m_ferr));
    check({tag, ".QUIESCENT"}, 32'(QUIESCENT), 32'(q_exp));
  endtask

  // drive one cycle's levels, let the rising edge consume them, return at negedge
  task automatic step();
    if (wq_l.size() > 0) UART_TXDLeft = wq_l.pop_front(); else UART_TXDLeft = idle_l;
    if (wq_r.size() > 0) UART_TXDRight = wq_r.pop_front(); else UART_TXDRight = idle_r;
    @(negedge XCLK);
  endtask

  task automatic add_bits(input int side, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (side == 0) wq_l.push_back(v); else wq_r.push_back(v);
    end
  endtask

  // idle gap, start bit, 8 data bits LSB first, stop bit
  task automatic send(input int side, input logic [7:0] b, input int gap);
    add_bits(side, 1'b1, gap);
    add_bits(side, 1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) add_bits(side, b[i], BIT_CYC);
    add_bits(side, 1'b1, BIT_CYC);
  endtask

  task automatic run_wave();
    while (wq_l.size() > 0 || wq_r.size() > 0) step();
    repeat (4) step();
  endtask

  task automatic do_reset(input logic lvl);
    wq_l.delete(); wq_r.delete();
    idle_l = lvl; idle_r = lvl;
    XRES = 1'b0;
    repeat (3) step();
    XRES = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [7:0] b, rb;
    int k;
    model_clear();
    @(negedge XCLK);

    // reset state
    do_reset(1'b1);
    check_all("reset");

    // 1) same byte on both sides, exact result latency
    send(0, 8'h55, 1);
    send(1, 8'h55, 1);
    repeat (41) step();
    check("t1_not_early", 32'(MATCH_CNT), 32'd0);
    step();
    model_push(0, 8'h55); model_push(1, 8'h55);
    check_all("t1");
    run_wave();
    check_all("t1_settled");

    // 2) skewed mismatch, then a match that must not disturb the capture
    do_reset(1'b1);
    send(0, 8'hA5, 1);
    send(1, 8'hA4, 38);
    run_wave();
    model_push(0, 8'hA5); model_push(1, 8'hA4);
    check_all("t2_mis");
    send(0, 8'h00, 1);
    send(1, 8'h00, 1);
    run_wave();
    model_push(0, 8'h00); model_push(1, 8'h00);
    check_all("t2_after");

    // 3) left overflow while right idle, then right drains the held bytes
    do_reset(1'b1);
    for (int i = 1; i <= 5; i++) begin
      send(0, 8'(i), 1);
      model_push(0, 8'(i));
    end
    run_wave();
    check_all("t3_ovf");
    for (int i = 1; i <= 4; i++) begin
      send(1, 8'(i), 1);
      model_push(1, 8'(i));
    end
    run_wave();
    check_all("t3_drain");

    // 4) right line low for a whole frame
    do_reset(1'b1);
    add_bits(1, 1'b1, 1);
    add_bits(1, 1'b0, 40);
    run_wave();
    m_ferr[1] = 1'b1;
    check_all("t4");

    // 5) lines low through reset release; no frame until they rise
    do_reset(1'b0);
    repeat (10) step();
    check_all("t5_low");
    idle_l = 1'b1; idle_r = 1'b1;
    send(0, 8'h3C, 1);
    send(1, 8'h3C, 1);
    run_wave();
    model_push(0, 8'h3C); model_push(1, 8'h3C);
    check_all("t5_send");

    // 6) reset pulse during left data bit 4, with buffered byte and sticky flag set
    do_reset(1'b1);
    send(0, 8'h11, 1);
    run_wave();
    model_push(0, 8'h11);
    add_bits(1, 1'b1, 1);
    add_bits(1, 1'b0, 40);
    run_wave();
    m_ferr[1] = 1'b1;
    check_all("t6_pre");
    send(0, 8'hF0, 1);
    repeat (22) step();
    XRES = 1'b0;
    step();
    XRES = 1'b1;
    model_clear();
    run_wave();
    check_all("t6_post");
    send(0, 8'h5A, 1);
    send(1, 8'h5A, 1);
    run_wave();
    model_push(0, 8'h5A); model_push(1, 8'h5A);
    check_all("t6_pair");

    // randomized rounds with independent per-side skew and occasional bit flips
    do_reset(1'b1);
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        rb = b;
        if ($urandom_range(0, 7) == 0) rb = b ^ 8'(1 << $urandom_range(0, 7));
        send(0, b, $urandom_range(1, 6));
        send(1, rb, (i == 0) ? $urandom_range(1, 30) : $urandom_range(1, 6));
        model_push(0, b);
        model_push(1, rb);
      end
      run_wave();
      check_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
